alu_mc_unit: RTL and testbench

//  Parametrised multi-cycle ALU, next generation of the datapath ALU. Same 6-bit opcode map, width set by WIDTH.

---
 rtl/alu_mc_if.sv | 29 ++
 rtl/alu_mc_unit.sv | 207 ++++++++++++++++++++
 tb/tb_alu_mc_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc_unit.
// master = control unit side, slave = ALU side.
interface alu_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zf;
  logic             cf;
  logic             nf;
  logic             of;
  logic             err;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, zf, cf, nf, of, err
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, result, zf, cf, nf, of, err
  );
endinterface

// File: rtl/alu_mc_unit.sv
// Multi-cycle ALU: registered single-cycle ops, iterative shift-add MUL and
// restoring DIV/MOD, valid/ready handshakes on both sides.
module alu_mc_unit #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef enum logic [5:0] {
    OP_ADD = 6'b001001, OP_SUB = 6'b001010, OP_LSR = 6'b001011,
    OP_LSL = 6'b001100, OP_ROR = 6'b001101, OP_ROL = 6'b001110,
    OP_MOV = 6'b001111, OP_MUL = 6'b010000, OP_DIV = 6'b010001,
    OP_MOD = 6'b010010, OP_AND = 6'b010011, OP_OR  = 6'b010100,
    OP_XOR = 6'b010101, OP_NEG = 6'b010110, OP_CMP = 6'b010111,
    OP_MAX = 6'b011000, OP_INC = 6'b011001, OP_DEC = 6'b011010
  } op_e;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   WVAL = (WIDTH+1)'(WIDTH);
  localparam logic [SHW-1:0]   LAST = SHW'(WIDTH-1);

  state_e state, state_n;

  logic [WIDTH-1:0] ia, ib;
  logic             accept, long_op;
  logic [WIDTH-1:0] opa, opb, acc, lo;
  logic [5:0]       opc;
  logic [SHW-1:0]   cnt;

  assign ia = bus.a;
  assign ib = bus.b;

  always_comb begin
    accept  = bus.in_valid && (state == S_IDLE);
    long_op = (bus.opcode == OP_MUL) ||
              (((bus.opcode == OP_DIV) || (bus.opcode == OP_MOD)) && (ib != '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept) state_n = long_op ? S_BUSY : S_DONE;
      S_BUSY: if (cnt == LAST) state_n = S_DONE;
      S_DONE: if (bus.out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
  end

  // Single-cycle results, computed straight from the accept-cycle operands.
  logic [WIDTH-1:0]   s_res;
  logic               s_cf, s_nf, s_of, s_err;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] ext;
  logic [SHW-1:0]     rs;

  always_comb begin
    s_res = '0;
    s_cf  = 1'b0;
    s_nf  = 1'b0;
    s_of  = 1'b0;
    s_err = 1'b0;
    sum   = '0;
    ext   = '0;
    rs    = SHW'(ib % WIDTH);
    case (bus.opcode)
      OP_ADD: begin
        sum   = {1'b0, ia} + {1'b0, ib};
        s_res = sum[WIDTH-1:0];
        s_cf  = sum[WIDTH];
        s_nf  = s_res[WIDTH-1];
        s_of  = (ia[WIDTH-1] == ib[WIDTH-1]) && (s_res[WIDTH-1] != ia[WIDTH-1]);
      end
      OP_SUB: begin
        sum   = {1'b0, ia} - {1'b0, ib};
        s_res = sum[WIDTH-1:0];
        s_cf  = ~sum[WIDTH];
        s_nf  = s_res[WIDTH-1];
        s_of  = (ia[WIDTH-1] != ib[WIDTH-1]) && (s_res[WIDTH-1] != ia[WIDTH-1]);
      end
      // The extra half of ext catches the last bit shifted out, including s==WIDTH.
      OP_LSR: begin
        ext   = {ia, {WIDTH{1'b0}}} >> ib;
        s_res = ext[2*WIDTH-1:WIDTH];
        s_cf  = ({1'b0, ib} > WVAL) ? 1'b0 : ext[WIDTH-1];
      end
      OP_LSL: begin
        ext   = {{WIDTH{1'b0}}, ia} << ib;
        s_res = ext[WIDTH-1:0];
        s_cf  = ({1'b0, ib} > WVAL) ? 1'b0 : ext[WIDTH];
      end
      OP_ROR: begin
        ext   = {ia, ia} >> rs;
        s_res = ext[WIDTH-1:0];
        s_cf  = (rs != '0) && s_res[WIDTH-1];
      end
      OP_ROL: begin
        ext   = {ia, ia} << rs;
        s_res = ext[2*WIDTH-1:WIDTH];
        s_cf  = (rs != '0) && s_res[0];
      end
      OP_MOV: s_res = ia;
      OP_MUL: s_res = '0;
      OP_DIV: begin s_res = '1; s_err = 1'b1; end
      OP_MOD: begin s_res = ia; s_err = 1'b1; end
      OP_AND: s_res = ia & ib;
      OP_OR:  s_res = ia | ib;
      OP_XOR: s_res = ia ^ ib;
      OP_NEG: begin
        s_res = ~ia + ONE;
        s_nf  = s_res[WIDTH-1];
        s_of  = (ia == MINV);
      end
      OP_CMP: begin
        s_res = {{(WIDTH-1){1'b0}}, ia != ib};
        s_nf  = ia < ib;
      end
      OP_MAX: s_res = (ia > ib) ? ia : ib;
      OP_INC: begin
        sum   = {1'b0, ia} + {1'b0, ONE};
        s_res = sum[WIDTH-1:0];
        s_cf  = sum[WIDTH];
      end
      OP_DEC: begin
        sum   = {1'b0, ia} - {1'b0, ONE};
        s_res = sum[WIDTH-1:0];
        s_cf  = (ia != '0);
        s_nf  = s_res[WIDTH-1];
      end
      default: s_err = 1'b1;
    endcase
  end

  // acc/lo: product high/low for MUL, remainder/dividend-quotient for DIV/MOD.
  logic [WIDTH:0]   it_sum, it_dif;
  logic [WIDTH-1:0] acc_n, lo_n, fin_res;
  logic             ge;

  always_comb begin
    it_sum = '0;
    it_dif = '0;
    ge     = 1'b0;
    if (opc == OP_MUL) begin
      it_sum = {1'b0, acc} + (lo[0] ? {1'b0, opa} : '0);
      acc_n  = it_sum[WIDTH:1];
      lo_n   = {it_sum[0], lo[WIDTH-1:1]};
    end else begin
      it_sum = {acc, lo[WIDTH-1]};
      it_dif = it_sum - {1'b0, opb};
      ge     = ~it_dif[WIDTH];
      acc_n  = ge ? it_dif[WIDTH-1:0] : it_sum[WIDTH-1:0];
      lo_n   = {lo[WIDTH-2:0], ge};
    end
    fin_res = (opc == OP_MOD) ? acc_n : lo_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa <= '0;  opb <= '0;  opc <= '0;
      acc <= '0;  lo  <= '0;  cnt <= '0;
      bus.result <= '0;
      bus.zf <= 1'b0;  bus.cf <= 1'b0;  bus.nf <= 1'b0;
      bus.of <= 1'b0;  bus.err <= 1'b0;
    end else if (accept) begin
      opa <= ia;
      opb <= ib;
      opc <= bus.opcode;
      acc <= '0;
      lo  <= (bus.opcode == OP_MUL) ? ib : ia;
      cnt <= '0;
      if (!long_op) begin
        bus.result <= s_res;
        bus.zf     <= (s_res == '0);
        bus.cf     <= s_cf;
        bus.nf     <= s_nf;
        bus.of     <= s_of;
        bus.err    <= s_err;
      end
    end else if (state == S_BUSY) begin
      acc <= acc_n;
      lo  <= lo_n;
      cnt <= cnt + SHW'(1);
      if (cnt == LAST) begin
        bus.result <= fin_res;
        bus.zf     <= (fin_res == '0);
        bus.cf     <= (opc == OP_MUL) && (acc_n != '0);
        bus.nf     <= 1'b0;
        bus.of     <= (opc == OP_MUL) && (acc_n != '0);
        bus.err    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc_unit.sv
// Bench for alu_mc_unit: directed cases plus random ops against an
// arithmetic reference model, including backpressure and mid-op reset.
module tb_alu_mc_unit;
  localparam int W = 16;

  localparam logic [5:0] ADD = 6'b001001, SUB = 6'b001010, LSR = 6'b001011,
                         LSL = 6'b001100, ROR = 6'b001101, ROL = 6'b001110,
                         MOV = 6'b001111, MUL = 6'b010000, DIV = 6'b010001,
                         MOD = 6'b010010, AND = 6'b010011, ORR = 6'b010100,
                         XOR = 6'b010101, NEG = 6'b010110, CMP = 6'b010111,
                         MAX = 6'b011000, INC = 6'b011001, DEC = 6'b011010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: expected result, {zf,cf,nf,of,err} and accept-to-valid latency.
  function automatic void model(input logic [5:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic [4:0] fl, output int lat);
    longint unsigned A, B, M, WL, full, s;
    longint sa, sb, sr, half;
    logic cf, nf, of, err;
    A = 64'(a);  B = 64'(b);  M = 64'd1 << W;  WL = 64'(W);
    half = longint'(M / 2);
    sa = a[W-1] ? longint'(A) - longint'(M) : longint'(A);
    sb = b[W-1] ? longint'(B) - longint'(M) : longint'(B);
    cf = 1'b0; nf = 1'b0; of = 1'b0; err = 1'b0; lat = 1;
    full = 0; sr = 0; s = B % WL;
    case (op)
      ADD: begin full = A + B; sr = sa + sb; cf = full >= M; of = sr >= half || sr < -half; end
      SUB: begin full = A + M - B; sr = sa - sb; cf = A >= B; of = sr >= half || sr < -half; end
      LSR: if (B == 0) full = A;
           else if (B < WL) begin full = A >> B; cf = ((A >> (B - 1)) & 1) == 1; end
           else if (B == WL) cf = a[W-1];
      LSL: if (B == 0) full = A;
           else if (B < WL) begin full = A << B; cf = ((A >> (WL - B)) & 1) == 1; end
           else if (B == WL) cf = a[0];
      ROR: full = (A >> s) | (A << (WL - s));
      ROL: full = (A << s) | (A >> (WL - s));
      MOV: full = A;
      MUL: begin full = A * B; cf = (full >> W) != 0; of = cf; lat = W + 1; end
      DIV: if (B == 0) begin full = M - 1; err = 1'b1; end
           else begin full = A / B; lat = W + 1; end
      MOD: if (B == 0) begin full = A; err = 1'b1; end
           else begin full = A % B; lat = W + 1; end
      AND: full = A & B;
      ORR: full = A | B;
      XOR: full = A ^ B;
      NEG: begin full = (M - A) % M; of = (A == M / 2); end
      CMP: begin full = (A != B) ? 1 : 0; nf = A < B; end
      MAX: full = (A > B) ? A : B;
      INC: begin full = A + 1; cf = (full == M); end
      DEC: begin full = (A + M - 1) % M; cf = (A != 0); end
      default: begin full = 0; err = 1'b1; end
    endcase
    r = full[W-1:0];
    if (op == ADD || op == SUB || op == NEG || op == DEC) nf = r[W-1];
    if (op == ROR) cf = (s != 0) && r[W-1];
    if (op == ROL) cf = (s != 0) && r[0];
    fl = {r == '0, cf, nf, of, err};
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge.
  task automatic run_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input string tag);
    logic [W-1:0] er;
    logic [4:0]   ef;
    int           el, k;
    model(op, a, b, er, ef, el);
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'(1));
    bus.in_valid  = 1'b1;
    bus.opcode    = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    k = 1;
    // Garbage offered while busy must be neither accepted nor observed.
    while (bus.out_valid !== 1'b1 && k < 4 * W + 8) begin
      bus.opcode = 6'($urandom);
      bus.a      = W'($urandom);
      bus.b      = W'($urandom);
      @(negedge clk);
      k++;
    end
    bus.in_valid = 1'b0;
    check({tag, " latency"}, 64'(k), 64'(el));
    check({tag, " result"}, 64'(bus.result), 64'(er));
    check({tag, " flags"}, 64'({bus.zf, bus.cf, bus.nf, bus.of, bus.err}), 64'(ef));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " hold"},
            64'({bus.out_valid, bus.in_ready, bus.result, bus.zf, bus.cf, bus.nf, bus.of, bus.err}),
            64'({1'b1, 1'b0, er, ef}));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, " release"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
  endtask

  logic [5:0] ops [18] = '{ADD, SUB, LSR, LSL, ROR, ROL, MOV, MUL, DIV,
                           MOD, AND, ORR, XOR, NEG, CMP, MAX, INC, DEC};

  initial begin
    logic [5:0]   rop;
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    check("reset handshake", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    check("reset result", 64'(bus.result), 64'(0));
    check("reset flags", 64'({bus.zf, bus.cf, bus.nf, bus.of, bus.err}), 64'(0));
    rst = 1'b0;

    run_op(ADD, W'(16'h7FFF), W'(16'h0001), 0, "add_ovf");
    run_op(MUL, W'(16'h0100), W'(16'h0100), 0, "mul_hi");
    run_op(MUL, W'(16'h00FF), W'(16'h0013), 0, "mul_lo");
    run_op(DIV, W'(17), W'(5), 0, "div");
    run_op(MOD, W'(17), W'(5), 0, "mod");
    run_op(DIV, W'(17), W'(0), 0, "div0");
    run_op(MOD, W'(9), W'(0), 0, "mod0");
    run_op(SUB, W'(2), W'(3), 5, "sub_stall");
    run_op(LSR, W'(16'h0011), W'(1), 0, "lsr1");
    run_op(ROL, W'(16'h8001), W'(1), 0, "rol1");
    run_op(LSL, W'(16'hFFFF), W'(20), 0, "lsl20");
    run_op(LSR, W'(16'h8000), W'(W), 0, "lsr_w");
    run_op(LSL, W'(16'h0001), W'(W), 0, "lsl_w");
    run_op(LSR, W'(16'hFFFF), W'(W + 1), 0, "lsr_w1");
    run_op(LSL, W'(16'h1234), W'(0), 0, "lsl0");
    run_op(ROR, W'(16'h0001), W'(W + 1), 0, "ror_mod");
    run_op(NEG, W'(16'h8000), W'(0), 0, "neg_min");
    run_op(CMP, W'(3), W'(5), 0, "cmp_lt");
    run_op(MAX, W'(16'h8000), W'(16'h7FFF), 0, "max");
    run_op(INC, W'(16'hFFFF), W'(0), 0, "inc_wrap");
    run_op(DEC, W'(0), W'(0), 0, "dec_zero");
    run_op(6'b000000, W'(5), W'(6), 0, "illegal0");
    run_op(6'b111111, W'(5), W'(6), 2, "illegal3f");

    // Reset during BUSY cycle 8 of a divide.
    bus.in_valid = 1'b1; bus.opcode = DIV; bus.a = W'(1000); bus.b = W'(7); bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst handshake", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
    check("midrst result", 64'(bus.result), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst handshake", 64'({bus.out_valid, bus.in_ready}), 64'(2'b01));
    run_op(ADD, W'(1), W'(1), 0, "postrst_add");

    for (int n = 0; n < 300; n++) begin
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 17)];
      ra  = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(0, 2 * W));
        default: rb = W'($urandom);
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 2), "rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
